// File: rtl/rv32i_pkg.sv
// Shared pipeline encodings for the RV32I core: writeback source, forward selects,
// hazard FSM states and the register-match helper (x0 never matches).
package rv32i_pkg;

  localparam logic [1:0] DTR_LOAD    = 2'b01;
  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_EXE_MEM = 2'b01;
  localparam logic [1:0] FWD_MEM_WB  = 2'b10;

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } hz_state_t;

  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] w, input logic we);
    return we && (w != 5'd0) && (r == w);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Free-running event counter that sticks at all-ones instead of wrapping.
// One cycle from inc to count; synchronous active-high reset.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst)
      r_count <= '0;
    else if (inc && (r_count != '1))
      r_count <= r_count + 1'b1;
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard control: stalls/flushes/bubbles are combinational, counters registered.
// Macro HAZARD_FORWARD_EN: defined = EXE operand forwarding + load-use stall; undefined = stall on any RAW.
module hazard_unit
  import rv32i_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ID_EXE_written_reg,
  input  logic [4:0]       ID_EXE_read_reg1,
  input  logic [4:0]       ID_EXE_read_reg2,
  input  logic             ID_EXE_reg_write,
  input  logic [1:0]       ID_EXE_data_to_reg,
  input  logic [4:0]       EXE_MEM_written_reg,
  input  logic             EXE_MEM_reg_write,
  input  logic [1:0]       EXE_MEM_data_to_reg,
  input  logic             EXE_MEM_mem_access,
  input  logic [4:0]       MEM_WB_written_reg,
  input  logic             MEM_WB_reg_write,
  input  logic             dmem_ready,
  input  logic             mispredict,
  output logic             PC_stall,
  output logic             IF_ID_stall,
  output logic             IF_ID_flush,
  output logic             ID_EXE_CE,
  output logic             ID_EXE_dstall,
  output logic             ID_EXE_cstall,
  output logic             EXE_MEM_CE,
  output logic             MEM_WB_bubble,
  output logic [1:0]       forward_A_sel,
  output logic [1:0]       forward_B_sel,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  logic w_mem_wait;
  logic w_hit_id_exe;
  logic w_data_haz;

  function automatic logic id_hit(input logic [4:0] w, input logic we,
                                  input logic [4:0] rs1, input logic u1,
                                  input logic [4:0] rs2, input logic u2);
    return (u1 && reg_match(rs1, w, we)) || (u2 && reg_match(rs2, w, we));
  endfunction

  assign w_mem_wait   = EXE_MEM_mem_access && !dmem_ready;
  assign w_hit_id_exe = id_hit(ID_EXE_written_reg, ID_EXE_reg_write,
                               id_rs1, id_rs1_used, id_rs2, id_rs2_used);

`ifdef HAZARD_FORWARD_EN
  function automatic logic [1:0] fwd_sel(input logic [4:0] r,
                                         input logic [4:0] em_w, input logic em_we,
                                         input logic [1:0] em_dtr,
                                         input logic [4:0] mw_w, input logic mw_we);
    if (reg_match(r, em_w, em_we) && (em_dtr != DTR_LOAD))
      return FWD_EXE_MEM;
    else if (reg_match(r, mw_w, mw_we))
      return FWD_MEM_WB;
    else
      return FWD_RF;
  endfunction

  // Only a load in EXE needs a stall; everything else is covered by forwarding.
  assign w_data_haz    = w_hit_id_exe && (ID_EXE_data_to_reg == DTR_LOAD);
  assign forward_A_sel = rst ? FWD_RF : fwd_sel(ID_EXE_read_reg1, EXE_MEM_written_reg,
                           EXE_MEM_reg_write, EXE_MEM_data_to_reg,
                           MEM_WB_written_reg, MEM_WB_reg_write);
  assign forward_B_sel = rst ? FWD_RF : fwd_sel(ID_EXE_read_reg2, EXE_MEM_written_reg,
                           EXE_MEM_reg_write, EXE_MEM_data_to_reg,
                           MEM_WB_written_reg, MEM_WB_reg_write);
`else
  logic w_unused;

  assign w_data_haz = w_hit_id_exe
                   || id_hit(EXE_MEM_written_reg, EXE_MEM_reg_write,
                             id_rs1, id_rs1_used, id_rs2, id_rs2_used)
                   || id_hit(MEM_WB_written_reg, MEM_WB_reg_write,
                             id_rs1, id_rs1_used, id_rs2, id_rs2_used);
  assign forward_A_sel = FWD_RF;
  assign forward_B_sel = FWD_RF;
  assign w_unused = ^{ID_EXE_read_reg1, ID_EXE_read_reg2, ID_EXE_data_to_reg, EXE_MEM_data_to_reg};
`endif

  always_comb begin
    PC_stall      = 1'b0;
    IF_ID_stall   = 1'b0;
    IF_ID_flush   = 1'b0;
    ID_EXE_CE     = 1'b1;
    ID_EXE_dstall = 1'b0;
    ID_EXE_cstall = 1'b0;
    EXE_MEM_CE    = 1'b1;
    MEM_WB_bubble = 1'b0;
    if (rst) begin
      PC_stall = 1'b0;
    end else if (w_mem_wait) begin
      // EXE stays frozen, so a pending mispredict is still asserted when the wait ends.
      PC_stall      = 1'b1;
      IF_ID_stall   = 1'b1;
      ID_EXE_CE     = 1'b0;
      EXE_MEM_CE    = 1'b0;
      MEM_WB_bubble = 1'b1;
    end else if (mispredict) begin
      IF_ID_flush   = 1'b1;
      ID_EXE_cstall = 1'b1;
    end else if (w_data_haz) begin
      PC_stall      = 1'b1;
      IF_ID_stall   = 1'b1;
      ID_EXE_dstall = 1'b1;
    end
  end

  hz_state_t     r_state;
  logic [TW-1:0] r_wait_cnt;
  logic          r_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mem_wait) begin
            r_state    <= MEMWAIT;
            r_wait_cnt <= TW'(1);
            if (MEM_TIMEOUT <= 1)
              r_timeout <= 1'b1;
          end
        end
        MEMWAIT: begin
          if (!w_mem_wait) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt != TW'(MEM_TIMEOUT)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
            if (r_wait_cnt == TW'(MEM_TIMEOUT - 1))
              r_timeout <= 1'b1;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign mem_timeout = r_timeout;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (PC_stall),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (IF_ID_flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with MEM_TIMEOUT=4; expectations follow HAZARD_FORWARD_EN.
module tb_hazard_unit;
  import rv32i_pkg::*;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_rs1_used, id_rs2_used;
  logic [4:0]  ID_EXE_written_reg, ID_EXE_read_reg1, ID_EXE_read_reg2;
  logic        ID_EXE_reg_write;
  logic [1:0]  ID_EXE_data_to_reg;
  logic [4:0]  EXE_MEM_written_reg;
  logic        EXE_MEM_reg_write;
  logic [1:0]  EXE_MEM_data_to_reg;
  logic        EXE_MEM_mem_access;
  logic [4:0]  MEM_WB_written_reg;
  logic        MEM_WB_reg_write;
  logic        dmem_ready;
  logic        mispredict;
  logic        PC_stall, IF_ID_stall, IF_ID_flush;
  logic        ID_EXE_CE, ID_EXE_dstall, ID_EXE_cstall, EXE_MEM_CE, MEM_WB_bubble;
  logic [1:0]  forward_A_sel, forward_B_sel;
  logic [31:0] stall_cycles, flush_count;
  logic        mem_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_st  = 0;

  always #5 clk = ~clk;

  hazard_unit #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ID_EXE_written_reg(ID_EXE_written_reg), .ID_EXE_read_reg1(ID_EXE_read_reg1),
    .ID_EXE_read_reg2(ID_EXE_read_reg2), .ID_EXE_reg_write(ID_EXE_reg_write),
    .ID_EXE_data_to_reg(ID_EXE_data_to_reg),
    .EXE_MEM_written_reg(EXE_MEM_written_reg), .EXE_MEM_reg_write(EXE_MEM_reg_write),
    .EXE_MEM_data_to_reg(EXE_MEM_data_to_reg), .EXE_MEM_mem_access(EXE_MEM_mem_access),
    .MEM_WB_written_reg(MEM_WB_written_reg), .MEM_WB_reg_write(MEM_WB_reg_write),
    .dmem_ready(dmem_ready), .mispredict(mispredict),
    .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall), .IF_ID_flush(IF_ID_flush),
    .ID_EXE_CE(ID_EXE_CE), .ID_EXE_dstall(ID_EXE_dstall), .ID_EXE_cstall(ID_EXE_cstall),
    .EXE_MEM_CE(EXE_MEM_CE), .MEM_WB_bubble(MEM_WB_bubble),
    .forward_A_sel(forward_A_sel), .forward_B_sel(forward_B_sel),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .mem_timeout(mem_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ID_EXE_written_reg = 5'd0; ID_EXE_read_reg1 = 5'd0; ID_EXE_read_reg2 = 5'd0;
    ID_EXE_reg_write = 1'b0; ID_EXE_data_to_reg = 2'b00;
    EXE_MEM_written_reg = 5'd0; EXE_MEM_reg_write = 1'b0; EXE_MEM_data_to_reg = 2'b00;
    EXE_MEM_mem_access = 1'b0; MEM_WB_written_reg = 5'd0; MEM_WB_reg_write = 1'b0;
    dmem_ready = 1'b1; mispredict = 1'b0;
  endtask

  initial begin
    // Reset: hazardous inputs must be ignored while rst is high.
    idle();
    rst = 1'b1;
    tick(); tick();
    EXE_MEM_mem_access = 1'b1; dmem_ready = 1'b0; mispredict = 1'b1;
    #1;
    chk("rst_pc_stall", PC_stall, 0);
    chk("rst_flush", IF_ID_flush, 0);
    chk("rst_ide_ce", ID_EXE_CE, 1);
    chk("rst_em_ce", EXE_MEM_CE, 1);
    chk("rst_bubble", MEM_WB_bubble, 0);
    chk("rst_fwd_a", forward_A_sel, 0);
    tick();
    chk("rst_stall_cnt", stall_cycles, 0);
    chk("rst_flush_cnt", flush_count, 0);
    chk("rst_timeout", mem_timeout, 0);
    chk("rst_state", 32'(dut.r_state), 32'(RUN));
    rst = 1'b0;
    idle();

    // Load-use: lw x5 in ID/EXE, ID reads x5.
    ID_EXE_reg_write = 1'b1; ID_EXE_data_to_reg = DTR_LOAD; ID_EXE_written_reg = 5'd5;
    id_rs1 = 5'd5; id_rs1_used = 1'b1;
    #1;
    chk("lu_pc_stall", PC_stall, 1);
    chk("lu_ifid_stall", IF_ID_stall, 1);
    chk("lu_dstall", ID_EXE_dstall, 1);
    chk("lu_cstall", ID_EXE_cstall, 0);
    chk("lu_em_ce", EXE_MEM_CE, 1);
    tick();
    exp_st = 1;
    chk("lu_stall_cnt", stall_cycles, exp_st);
    // The load advances into EXE/MEM.
    ID_EXE_reg_write = 1'b0; ID_EXE_written_reg = 5'd0;
    EXE_MEM_reg_write = 1'b1; EXE_MEM_data_to_reg = DTR_LOAD; EXE_MEM_written_reg = 5'd5;
    #1;
    chk("lu_next_dstall", ID_EXE_dstall, FWD ? 0 : 1);
    tick();
    exp_st += FWD ? 0 : 1;
    chk("lu_next_stall_cnt", stall_cycles, exp_st);
    idle();
    // x0 never matches; an unused source never stalls.
    ID_EXE_reg_write = 1'b1; ID_EXE_data_to_reg = DTR_LOAD; ID_EXE_written_reg = 5'd0;
    id_rs1_used = 1'b1;
    #1;
    chk("lu_x0", ID_EXE_dstall, 0);
    ID_EXE_written_reg = 5'd9; id_rs2 = 5'd9; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    #1;
    chk("lu_unused", ID_EXE_dstall, 0);
    idle();

    // Forwarding priority.
    EXE_MEM_reg_write = 1'b1; EXE_MEM_written_reg = 5'd7;
    MEM_WB_reg_write = 1'b1; MEM_WB_written_reg = 5'd7;
    ID_EXE_read_reg2 = 5'd7;
    #1;
    chk("fwd_b_exemem", forward_B_sel, FWD ? 2'b01 : 2'b00);
    chk("fwd_a_none", forward_A_sel, 2'b00);
    EXE_MEM_reg_write = 1'b0;
    #1;
    chk("fwd_b_memwb", forward_B_sel, FWD ? 2'b10 : 2'b00);
    EXE_MEM_reg_write = 1'b1; EXE_MEM_data_to_reg = DTR_LOAD;
    #1;
    chk("fwd_b_load_skip", forward_B_sel, FWD ? 2'b10 : 2'b00);
    EXE_MEM_data_to_reg = 2'b00; ID_EXE_read_reg1 = 5'd7;
    #1;
    chk("fwd_a_exemem", forward_A_sel, FWD ? 2'b01 : 2'b00);
    EXE_MEM_written_reg = 5'd0; MEM_WB_written_reg = 5'd0;
    ID_EXE_read_reg1 = 5'd0; ID_EXE_read_reg2 = 5'd0;
    #1;
    chk("fwd_b_x0", forward_B_sel, 2'b00);
    chk("fwd_a_x0", forward_A_sel, 2'b00);
    idle();

    // Memory wait of 3 cycles.
    EXE_MEM_mem_access = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_em_ce", EXE_MEM_CE, 0);
      chk("mw_bubble", MEM_WB_bubble, 1);
      chk("mw_ide_ce", ID_EXE_CE, 0);
      chk("mw_pc_stall", PC_stall, 1);
      tick();
      chk("mw_state", 32'(dut.r_state), 32'(MEMWAIT));
    end
    exp_st += 3;
    dmem_ready = 1'b1;
    #1;
    chk("mw_done_em_ce", EXE_MEM_CE, 1);
    chk("mw_done_pc_stall", PC_stall, 0);
    tick();
    chk("mw_stall_cnt", stall_cycles, exp_st);
    chk("mw_state_run", 32'(dut.r_state), 32'(RUN));
    chk("mw_no_timeout", mem_timeout, 0);
    idle();

    // Mispredict held across a 2-cycle wait.
    EXE_MEM_mem_access = 1'b1; dmem_ready = 1'b0; mispredict = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("mpw_flush", IF_ID_flush, 0);
      chk("mpw_cstall", ID_EXE_cstall, 0);
      tick();
    end
    exp_st += 2;
    dmem_ready = 1'b1;
    #1;
    chk("mpw_end_flush", IF_ID_flush, 1);
    chk("mpw_end_cstall", ID_EXE_cstall, 1);
    chk("mpw_end_pc_stall", PC_stall, 0);
    tick();
    chk("mpw_flush_cnt", flush_count, 1);
    chk("mpw_stall_cnt", stall_cycles, exp_st);
    // Mispredict outranks load-use.
    idle();
    mispredict = 1'b1;
    ID_EXE_reg_write = 1'b1; ID_EXE_data_to_reg = DTR_LOAD; ID_EXE_written_reg = 5'd4;
    id_rs2 = 5'd4; id_rs2_used = 1'b1;
    #1;
    chk("mp_lu_flush", IF_ID_flush, 1);
    chk("mp_lu_dstall", ID_EXE_dstall, 0);
    chk("mp_lu_pc_stall", PC_stall, 0);
    tick();
    chk("mp_flush_cnt", flush_count, 2);
    idle();

    // Timeout after 4 wait cycles, sticky until rst.
    EXE_MEM_mem_access = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 3) chk("to_before", mem_timeout, 0);
      if (i == 4) chk("to_set", mem_timeout, 1);
    end
    exp_st += 6;
    dmem_ready = 1'b1;
    tick();
    chk("to_sticky", mem_timeout, 1);
    chk("to_state_run", 32'(dut.r_state), 32'(RUN));
    chk("to_stall_cnt", stall_cycles, exp_st);
    dmem_ready = 1'b0;
    tick();
    chk("to_rewait", 32'(dut.r_state), 32'(MEMWAIT));
    rst = 1'b1;
    #1;
    chk("rst_mid_pc_stall", PC_stall, 0);
    chk("rst_mid_em_ce", EXE_MEM_CE, 1);
    tick();
    chk("rst_mid_state", 32'(dut.r_state), 32'(RUN));
    chk("rst_mid_timeout", mem_timeout, 0);
    chk("rst_mid_stall_cnt", stall_cycles, 0);
    chk("rst_mid_flush_cnt", flush_count, 0);
    rst = 1'b0;
    idle();

    // add x3 ahead of an instruction reading x3 through rs2.
    EXE_MEM_reg_write = 1'b1; EXE_MEM_written_reg = 5'd3;
    id_rs2 = 5'd3; id_rs2_used = 1'b1;
    #1;
    chk("raw_em_dstall", ID_EXE_dstall, FWD ? 0 : 1);
    tick();
    EXE_MEM_reg_write = 1'b0; EXE_MEM_written_reg = 5'd0;
    MEM_WB_reg_write = 1'b1; MEM_WB_written_reg = 5'd3;
    #1;
    chk("raw_mw_dstall", ID_EXE_dstall, FWD ? 0 : 1);
    tick();
    MEM_WB_reg_write = 1'b0; MEM_WB_written_reg = 5'd0;
    #1;
    chk("raw_release", ID_EXE_dstall, 0);
    chk("raw_release_pc", PC_stall, 0);
    tick();
    chk("raw_stall_cnt", stall_cycles, FWD ? 0 : 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage RV32I core. Watches register indices and control bits in the ID, ID/EXE, EXE/MEM and MEM/WB stages, plus data-memory readiness and branch-mispredict resolution from EXE. Drives the stall, bubble, flush and clock-enable inputs of every pipeline register, and the EXE-stage operand-forwarding selects. Also keeps saturating performance counters and a sticky memory-timeout flag.

## Interface
- MEM_TIMEOUT, 255: consecutive not-ready cycles before `mem_timeout` sets.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_rs1_used, id_rs2_used  in  1 each  the ID instruction actually reads rs1 / rs2
- ID_EXE_written_reg, ID_EXE_read_reg1, ID_EXE_read_reg2  in  5 each  register indices of the EXE instruction
- ID_EXE_reg_write  in  1  EXE instruction writes a register
- ID_EXE_data_to_reg  in  2  EXE instruction writeback source (2'b01 = load)
- EXE_MEM_written_reg  in  5;  EXE_MEM_reg_write  in  1;  EXE_MEM_data_to_reg  in  2  MEM-stage destination and writeback info
- EXE_MEM_mem_access  in  1  MEM instruction is a load or store
- MEM_WB_written_reg  in  5;  MEM_WB_reg_write  in  1  WB-stage destination
- dmem_ready  in  1  data memory completes the access this cycle
- mispredict  in  1  EXE resolved the branch opposite to the prediction; the fetch redirect to fallback PC happens this cycle
- PC_stall, IF_ID_stall  out  1 each  hold the PC / hold IF/ID
- IF_ID_flush  out  1  load a NOP into IF/ID
- ID_EXE_CE, ID_EXE_dstall, ID_EXE_cstall  out  1 each  ID/EXE enable, data bubble, control bubble
- EXE_MEM_CE  out  1  EXE/MEM enable
- MEM_WB_bubble  out  1  load a NOP into MEM/WB
- forward_A_sel, forward_B_sel  out  2 each  operand source: 00 register file, 01 EXE/MEM ALU result, 10 MEM/WB writeback data
- stall_cycles, flush_count  out  CNT_W each  performance counters
- mem_timeout  out  1  sticky; set when a memory wait reaches MEM_TIMEOUT cycles

## Operation
Hazard terms (all combinational):
- `match(r, w, we)`: true when `we` is 1, `w` is non-zero, and `r == w`. Register x0 never matches.
- `mem_wait`: `EXE_MEM_mem_access` and not `dmem_ready`.
- `load_use`: `ID_EXE_reg_write`, `ID_EXE_data_to_reg == 2'b01`, and a used ID source register matches `ID_EXE_written_reg`.

Priority: rst > mem_wait > mispredict > load_use.
- **mem_wait:** PC_stall=1, IF_ID_stall=1, ID_EXE_CE=0, EXE_MEM_CE=0, MEM_WB_bubble=1. A mispredict is ignored this cycle; it is taken when the wait ends, because EXE is frozen and `mispredict` stays asserted.
- **mispredict:** IF_ID_flush=1, ID_EXE_cstall=1. PC is not stalled, so the redirect loads. flush_count increments.
- **load_use:** PC_stall=1, IF_ID_stall=1, ID_EXE_dstall=1, for exactly one cycle per hazard.
- **Otherwise:** all stall, flush and bubble outputs are 0; ID_EXE_CE=1 and EXE_MEM_CE=1.
- **stall_cycles** increments on every cycle with PC_stall=1.
- **Both counters** saturate at all-ones.

Forwarding, for the EXE operands `ID_EXE_read_reg1` / `ID_EXE_read_reg2`:
- Select 01 if the operand matches EXE/MEM and `EXE_MEM_data_to_reg != 2'b01`.
- Otherwise select 10 if it matches MEM/WB.
- Otherwise select 00.
- EXE/MEM takes priority over MEM/WB.

FSM `RUN` / `MEMWAIT`, plus a wait counter:
- RUN→MEMWAIT on the first cycle `mem_wait` is 1; the counter loads 1.
- In MEMWAIT the counter increments each cycle `mem_wait` stays 1.
- `mem_timeout` sets when the counter reaches MEM_TIMEOUT.
- MEMWAIT→RUN on the cycle `dmem_ready` is 1; the counter clears.
- `mem_timeout` clears only on rst.

## Timing
- Stall, flush and bubble outputs and the forward selects are combinational from the current inputs. They act at the next clk edge; there is no added latency.
- Counters, FSM state and `mem_timeout` update on the clk rising edge.
- While rst=1: every stall, flush and bubble output is 0; ID_EXE_CE=1; EXE_MEM_CE=1; forward selects are 00; counters are 0; state is RUN; `mem_timeout` is 0.
- Asserting rst mid-wait returns the FSM to RUN on the next edge.
- If `dmem_ready` rises in the same cycle as `mispredict`, the flush takes effect in that cycle.

## Configuration
- `HAZARD_FORWARD_EN` defined: forwarding as described above.
- `HAZARD_FORWARD_EN` undefined:
  - forward_A_sel and forward_B_sel are tied to 00.
  - `load_use` is replaced by `raw`: a used ID source matches the ID/EXE, EXE/MEM or MEM/WB destination.
  - `raw` produces the same stall response and the same priority as `load_use`, and it repeats until there is no match.
  - A RAW hazard on the instruction directly ahead therefore costs up to 3 cycles.

## Structure
- Shared package `rv32i_pkg` holds:
  - DTR_LOAD = 2'b01
  - FWD_RF = 2'b00, FWD_EXE_MEM = 2'b01, FWD_MEM_WB = 2'b10
  - state enum `hz_state_t` {RUN, MEMWAIT}
- Sub-module `sat_counter` (parameter W; ports clk, rst, inc, count) is instantiated twice for the performance counters.

## Test plan
- **Load-use:** lw x5 in ID/EXE (data_to_reg=01, written_reg=5); ID rs1=5 used → PC_stall, IF_ID_stall, ID_EXE_dstall =1 for one cycle; stall_cycles=1.
- **Forward priority:** EXE/MEM and MEM/WB both write x7; ID_EXE_read_reg2=7 → forward_B_sel=01. Same with EXE/MEM not writing → 10. Register x0 in both → 00.
- **Memory wait:** EXE_MEM_mem_access=1, dmem_ready low for 3 cycles → EXE_MEM_CE=0 and MEM_WB_bubble=1 for 3 cycles; stall_cycles=3; FSM returns to RUN.
- **Mispredict during wait:** mispredict held across the wait → no flush while waiting; IF_ID_flush and ID_EXE_cstall assert in the cycle dmem_ready=1; flush_count=1.
- **Timeout:** MEM_TIMEOUT=4, dmem_ready held low for 6 cycles → mem_timeout=1 after the 4th wait cycle and stays 1 after the wait ends; rst clears it.
- **Without HAZARD_FORWARD_EN:** add x3 in EXE/MEM; ID rs2=3 used → dstall for 2 cycles, then released.
